uc_multiciclo: RTL and testbench
================================

# uc_multiciclo

Multicycle control unit for the RV32I subset processor (lw, sw, R-type, I-type ALU, beq, jal). It is a Moore FSM that sequences the shared datapath: one memory, one ALU and the instruction register. Each instruction takes 3–5 cycles. It sits beside the datapath in `Modulos/` and decodes `op`/`f3`/`f7` from the instruction register.

## Interface
Parameters:
- none; state and opcode encodings come from the shared header.

Ports:
- `clk`  input  1  — single clock; all state updates on the rising edge.
- `reset`  input  1  — synchronous, active-high. Forces state to FETCH.
- `op`  input  7  — instr[6:0] from the instruction register.
- `f3`  input  3  — instr[14:12].
- `f7`  input  1  — instr[30].
- `zero`  input  1  — ALU zero flag.
- `pcWrite`  output  1  — PC load enable.
- `adrSrc`  output  1  — memory address select: 0 = PC, 1 = ALU result register.
- `memWrite`  output  1  — data memory write enable.
- `irWrite`  output  1  — instruction register and oldPC load.
- `resSrc`  output  2  — result mux: 00 = ALUOut, 01 = Data, 10 = ALU result.
- `aluSrcA`  output  2  — 00 = PC, 01 = oldPC, 10 = rs1 register.
- `aluSrcB`  output  2  — 00 = rs2 register, 01 = immediate, 10 = constant 4.
- `inmSrc`  output  2  — 00 = I, 01 = S, 10 = B, 11 = J.
- `regWrite`  output  1  — register file write enable.
- `aluControl`  output  3  — 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `estado`  output  4  — current state, for debug and the testbench.
- `ilegal`  output  1  — illegal-opcode flag. Exists only with `UC_TRAP_ILEGAL_EN`.

## Operation
- **Output decoding:**
  - All outputs are decoded from `estado` alone, except `pcWrite`.
  - `pcWrite = pcUpdate | (branch & zero)`. `branch` and `pcUpdate` are internal signals.
  - Unlisted outputs in a state are 0.
- **FETCH:**
  - Outputs: adrSrc=0, irWrite=1, aluSrcA=00, aluSrcB=10, aluOp=00, resSrc=10, pcUpdate=1.
  - Next state: DECODE.
- **DECODE:**
  - Outputs: aluSrcA=01, aluSrcB=01, aluOp=00, inmSrc=10. This computes the branch target.
  - Next state by op:
    - lw or sw → MEMADR
    - R-type → EXECUTER
    - I-type → EXECUTEI
    - jal → JAL
    - beq → BEQ
    - any other op → FETCH, or ILEGAL when the trap is enabled.
- **MEMADR:**
  - Outputs: aluSrcA=10, aluSrcB=01, aluOp=00. inmSrc=00 for lw, 01 for sw.
  - Next state: MEMREAD for lw, MEMWRITE for sw.
- **MEMREAD:** resSrc=00, adrSrc=1 → MEMWB.
- **MEMWB:** resSrc=01, regWrite=1 → FETCH.
- **MEMWRITE:** resSrc=00, adrSrc=1, memWrite=1 → FETCH.
- **EXECUTER:** aluSrcA=10, aluSrcB=00, aluOp=10 → ALUWB.
- **EXECUTEI:** aluSrcA=10, aluSrcB=01, aluOp=10, inmSrc=00 → ALUWB.
- **ALUWB:** resSrc=00, regWrite=1 → FETCH.
- **BEQ:**
  - Outputs: aluSrcA=10, aluSrcB=00, aluOp=01, resSrc=00, branch=1.
  - Next state: FETCH.
- **JAL:**
  - Outputs: aluSrcA=01, aluSrcB=10, aluOp=00, resSrc=00, pcUpdate=1.
  - Next state: ALUWB.
- **ALU decode:**
  - aluOp 00 → add.
  - aluOp 01 → sub.
  - aluOp 10 → by f3:
    - 000: sub if `op[5] & f7`, else add.
    - 010: slt.
    - 110: or.
    - 111: and.
    - other: add.
- **Invalid state codes:** next state is FETCH and all enables are 0.

## Timing
- **Reset:**
  - While `reset`=1, all enables (pcWrite, memWrite, irWrite, regWrite) are forced to 0.
  - `estado` = FETCH on the first edge with `reset`=1.
  - Reset mid-instruction drops the pending write. A MEMWRITE or ALUWB interrupted by reset produces no write.
- **Latency, counted from the FETCH cycle to the next FETCH:**
  - lw: 5 cycles.
  - sw, R-type, I-type, jal: 4 cycles.
  - beq: 3 cycles.
- **Input sampling:**
  - `op`, `f3` and `f7` are only sampled from DECODE onward. The instruction register is stable from then on.
  - `zero` is used combinationally in BEQ only.
- **beq:** taken and not-taken branches have identical latency.

## Configuration
- **`UC_TRAP_ILEGAL_EN` defined:**
  - An unknown op in DECODE enters ILEGAL. ILEGAL is absorbing and all enables are 0 there.
  - `ilegal`=1 while in ILEGAL.
  - Only `reset` exits ILEGAL.
- **`UC_TRAP_ILEGAL_EN` undefined:**
  - An unknown op goes DECODE → FETCH. The instruction executes as a 2-cycle NOP.
  - There is no `ilegal` port and no ILEGAL state.

## Structure
- **Shared header `Componentes/constantes_uc.vh`:**
  - `` `define `` constants for the 12 state codes (4-bit; FETCH = 0).
  - The six opcodes.
  - The aluControl codes.
- **Sub-module:** the ALU decode is the existing `aluDeco`, instantiated unchanged and fed by the FSM's `aluOp`. The FSM and output decode stay in `uc_multiciclo`.

## Test plan
- **Reset:** reset=1 for 2 cycles with op=0110011 → estado=FETCH, all enables 0. After release, irWrite=1 and pcWrite=1 in the first cycle.
- **lw:** op=0000011 → estados FETCH, DECODE, MEMADR, MEMREAD, MEMWB. regWrite=1 only in cycle 5 with resSrc=01.
- **sub:** op=0110011, f3=000, f7=1 → aluControl=001 in EXECUTER. Then ALUWB with regWrite=1; 4 cycles total.
- **beq:** op=1100011 with zero=1 → pcWrite=1 in BEQ. Repeat with zero=0 → pcWrite=0. Both return to FETCH after 3 cycles.
- **sw with mid-instruction reset:** op=0100011, reset asserted in MEMADR → no memWrite pulse, estado=FETCH next cycle.
- **Illegal opcode:** op=1111111 with `UC_TRAP_ILEGAL_EN` → ILEGAL, ilegal=1, held for 10 cycles. Without the macro → back in FETCH after 2 cycles.

Source files
------------

// File: rtl/uc_multiciclo_pkg.sv
// Shared state, opcode and ALU-control encodings for the multicycle control unit.
package uc_multiciclo_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_ILEGAL   = 4'd11;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/uc_multiciclo_alu_deco.sv
// ALU decoder: maps the FSM's aluOp plus funct fields to an aluControl code.
module uc_multiciclo_alu_deco
  import uc_multiciclo_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic       op5,
  input  logic [2:0] f3,
  input  logic       f7,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      2'b01: alu_control = ALU_SUB;
      2'b10: begin
        case (f3)
          // Only R-type (op[5]=1) may turn funct7[5] into a subtract.
          3'b000:  alu_control = (op5 & f7) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Moore FSM sequencing the shared RV32I datapath (lw, sw, R, I, beq, jal).
// Optional illegal-opcode trap state is built when UC_TRAP_ILEGAL_EN is defined.
module uc_multiciclo
  import uc_multiciclo_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] f3,
  input  logic       f7,
  input  logic       zero,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic [1:0] resSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] inmSrc,
  output logic       regWrite,
  output logic [2:0] aluControl,
`ifdef UC_TRAP_ILEGAL_EN
  output logic       ilegal,
`endif
  output logic [3:0] estado
);

  // state    | meaning
  // FETCH    | read instr at PC, PC <= PC+4
  // DECODE   | read regs, ALUOut <= oldPC + immB
  // MEMADR   | ALUOut <= rs1 + imm
  // MEMREAD  | Data <= mem[ALUOut]
  // MEMWB    | rd <= Data
  // MEMWRITE | mem[ALUOut] <= rs2
  // EXECUTER | ALUOut <= rs1 op rs2
  // EXECUTEI | ALUOut <= rs1 op imm
  // ALUWB    | rd <= ALUOut
  // BEQ      | compare, PC <= ALUOut if zero
  // JAL      | PC <= ALUOut, ALUOut <= oldPC+4
  // ILEGAL   | trap, absorbing until reset

  logic [3:0] state, state_next;
  logic [1:0] alu_op;
  logic       branch, pc_update, ir_w, reg_w, mem_w;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
`ifdef UC_TRAP_ILEGAL_EN
          default:      state_next = S_ILEGAL;
`else
          default:      state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_next = S_MEMWB;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_JAL:      state_next = S_ALUWB;
`ifdef UC_TRAP_ILEGAL_EN
      S_ILEGAL:   state_next = S_ILEGAL;
`endif
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    adrSrc    = 1'b0;
    resSrc    = 2'b00;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    inmSrc    = 2'b00;
    alu_op    = 2'b00;
    branch    = 1'b0;
    pc_update = 1'b0;
    ir_w      = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    case (state)
      S_FETCH: begin
        ir_w = 1'b1; aluSrcB = 2'b10; resSrc = 2'b10; pc_update = 1'b1;
      end
      S_DECODE: begin
        aluSrcA = 2'b01; aluSrcB = 2'b01; inmSrc = 2'b10;
      end
      S_MEMADR: begin
        aluSrcA = 2'b10; aluSrcB = 2'b01;
        inmSrc  = (op == OP_SW) ? 2'b01 : 2'b00;
      end
      S_MEMREAD:  adrSrc = 1'b1;
      S_MEMWB: begin
        resSrc = 2'b01; reg_w = 1'b1;
      end
      S_MEMWRITE: begin
        adrSrc = 1'b1; mem_w = 1'b1;
      end
      S_EXECUTER: begin
        aluSrcA = 2'b10; alu_op = 2'b10;
      end
      S_EXECUTEI: begin
        aluSrcA = 2'b10; aluSrcB = 2'b01; alu_op = 2'b10;
      end
      S_ALUWB:    reg_w = 1'b1;
      S_BEQ: begin
        aluSrcA = 2'b10; alu_op = 2'b01; branch = 1'b1;
      end
      S_JAL: begin
        aluSrcA = 2'b01; aluSrcB = 2'b10; pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset gates every enable so an interrupted instruction never commits.
  assign pcWrite  = ~reset & (pc_update | (branch & zero));
  assign irWrite  = ~reset & ir_w;
  assign regWrite = ~reset & reg_w;
  assign memWrite = ~reset & mem_w;
  assign estado   = state;

`ifdef UC_TRAP_ILEGAL_EN
  assign ilegal = (state == S_ILEGAL);
`endif

  uc_multiciclo_alu_deco u_alu_deco (
    .alu_op      (alu_op),
    .op5         (op[5]),
    .f3          (f3),
    .f7          (f7),
    .alu_control (aluControl)
  );

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed bench for uc_multiciclo: per-cycle state/enable vectors with hand-computed values.
module tb_uc_multiciclo;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7, zero;
  logic       pcWrite, adrSrc, memWrite, irWrite, regWrite;
  logic [1:0] resSrc, aluSrcA, aluSrcB, inmSrc;
  logic [2:0] aluControl;
  logic [3:0] estado;
`ifdef UC_TRAP_ILEGAL_EN
  logic       ilegal;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uc_multiciclo dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .f3         (f3),
    .f7         (f7),
    .zero       (zero),
    .pcWrite    (pcWrite),
    .adrSrc     (adrSrc),
    .memWrite   (memWrite),
    .irWrite    (irWrite),
    .resSrc     (resSrc),
    .aluSrcA    (aluSrcA),
    .aluSrcB    (aluSrcB),
    .inmSrc     (inmSrc),
    .regWrite   (regWrite),
    .aluControl (aluControl),
`ifdef UC_TRAP_ILEGAL_EN
    .ilegal     (ilegal),
`endif
    .estado     (estado)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check state and the four enables in the current cycle, then advance one clock.
  task automatic step(input string tag, input logic [3:0] st, input logic pcw,
                      input logic regw, input logic memw, input logic irw);
    check({tag, ".estado"},   32'(estado),   32'(st));
    check({tag, ".pcWrite"},  32'(pcWrite),  32'(pcw));
    check({tag, ".regWrite"}, 32'(regWrite), 32'(regw));
    check({tag, ".memWrite"}, 32'(memWrite), 32'(memw));
    check({tag, ".irWrite"},  32'(irWrite),  32'(irw));
    tick();
  endtask

  initial begin
    reset = 1'b1; op = 7'b0110011; f3 = 3'b000; f7 = 1'b0; zero = 1'b0;
    tick();
    step("rst1", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst2.estado", 32'(estado), 32'd0);
    check("rst2.irWrite", 32'(irWrite), 32'd0);
    reset = 1'b0;
    #1;
    check("rel.irWrite", 32'(irWrite), 32'd1);
    check("rel.pcWrite", 32'(pcWrite), 32'd1);

    // lw: 5 cycles
    op = 7'b0000011;
    check("lw.fetch.aluControl", 32'(aluControl), 32'b000);
    check("lw.fetch.resSrc", 32'(resSrc), 32'b10);
    step("lw.fetch",   4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("lw.decode.inmSrc", 32'(inmSrc), 32'b10);
    step("lw.decode",  4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lw.memadr.inmSrc", 32'(inmSrc), 32'b00);
    check("lw.memadr.aluSrcA", 32'(aluSrcA), 32'b10);
    step("lw.memadr",  4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lw.memread.adrSrc", 32'(adrSrc), 32'd1);
    step("lw.memread", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lw.memwb.resSrc", 32'(resSrc), 32'b01);
    step("lw.memwb",   4'd4, 1'b0, 1'b1, 1'b0, 1'b0);

    // sub: 4 cycles
    op = 7'b0110011; f3 = 3'b000; f7 = 1'b1;
    step("sub.fetch",  4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("sub.decode", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sub.aluControl", 32'(aluControl), 32'b001);
    step("sub.exec",   4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    step("sub.aluwb",  4'd8, 1'b0, 1'b1, 1'b0, 1'b0);

    // R-type or
    f3 = 3'b110; f7 = 1'b0;
    step("or.fetch",  4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("or.decode", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("or.aluControl", 32'(aluControl), 32'b011);
    step("or.exec",   4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    step("or.aluwb",  4'd8, 1'b0, 1'b1, 1'b0, 1'b0);

    // addi with instr[30]=1 must stay add (op[5]=0)
    op = 7'b0010011; f3 = 3'b000; f7 = 1'b1;
    step("addi.fetch",  4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("addi.decode", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("addi.aluControl", 32'(aluControl), 32'b000);
    check("addi.aluSrcB", 32'(aluSrcB), 32'b01);
    step("addi.exec",   4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step("addi.aluwb",  4'd8, 1'b0, 1'b1, 1'b0, 1'b0);

    // slti and andi
    f3 = 3'b010; f7 = 1'b0;
    step("slti.fetch",  4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("slti.decode", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("slti.aluControl", 32'(aluControl), 32'b101);
    step("slti.exec",   4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step("slti.aluwb",  4'd8, 1'b0, 1'b1, 1'b0, 1'b0);
    f3 = 3'b111;
    step("andi.fetch",  4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("andi.decode", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("andi.aluControl", 32'(aluControl), 32'b010);
    step("andi.exec",   4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step("andi.aluwb",  4'd8, 1'b0, 1'b1, 1'b0, 1'b0);

    // beq taken / not taken: 3 cycles each
    op = 7'b1100011; f3 = 3'b000; zero = 1'b1;
    step("beqT.fetch",  4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("beqT.decode", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("beqT.aluControl", 32'(aluControl), 32'b001);
    step("beqT.beq",    4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    zero = 1'b0;
    step("beqN.fetch",  4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("beqN.decode", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("beqN.beq",    4'd9, 1'b0, 1'b0, 1'b0, 1'b0);

    // jal: 4 cycles
    op = 7'b1101111;
    step("jal.fetch",  4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("jal.decode", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("jal.aluSrcA", 32'(aluSrcA), 32'b01);
    check("jal.aluSrcB", 32'(aluSrcB), 32'b10);
    step("jal.jal",    4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    step("jal.aluwb",  4'd8, 1'b0, 1'b1, 1'b0, 1'b0);

    // sw: 4 cycles
    op = 7'b0100011;
    step("sw.fetch",  4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("sw.decode", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sw.memadr.inmSrc", 32'(inmSrc), 32'b01);
    step("sw.memadr", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sw.memwrite.adrSrc", 32'(adrSrc), 32'd1);
    step("sw.memwrite", 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);

    // sw interrupted by reset in MEMADR: no write, back in FETCH
    step("swr.fetch",  4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("swr.decode", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    step("swr.memadr", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    check("swr.after.estado", 32'(estado), 32'd0);
    check("swr.after.memWrite", 32'(memWrite), 32'd0);
    reset = 1'b0;
    #1;

    // Unknown opcode
    op = 7'b1111111;
    step("ill.fetch",  4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("ill.decode", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef UC_TRAP_ILEGAL_EN
    for (int i = 0; i < 10; i++) begin
      check("ill.ilegal", 32'(ilegal), 32'd1);
      step("ill.hold", 4'd11, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("ill.exit.estado", 32'(estado), 32'd0);
    check("ill.exit.ilegal", 32'(ilegal), 32'd0);
`else
    step("ill.nop", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    op = 7'b0110011;
    step("ill.next", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
